// File: rtl/dcounter_sync.sv
// Up/down counter fed by raw active-low push-buttons. Each button is synchronised,
// debounced and edge-detected, so one physical press gives exactly one count step.
module dcounter_sync #(
    parameter int             N               = 6,
    parameter int             DEBOUNCE_CYCLES = 4,
    parameter bit             WRAP            = 1'b0,
    parameter logic [N-1:0]   RESET_VAL       = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         btn_reset,
    input  logic         btn_increment,
    input  logic         btn_decrement,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] count,
    output logic         at_max,
    output logic         at_min,
    output logic         overflow,
    output logic         underflow
);

    localparam int              CW          = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0]    MAX_VAL     = {N{1'b1}};

    logic [1:0] btn_raw;
    logic [1:0] press_ev;
    logic       inc_ev;
    logic       dec_ev;

    assign btn_raw = {btn_decrement, btn_increment};

    // Bit 0 is the increment button, bit 1 the decrement button; both paths are identical.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic          meta;
        logic          sync;
        logic          db;
        logic          db_q;
        logic [CW-1:0] stable_cnt;

        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge value of its neighbours, which is what makes the 2-flop chain a chain.
        always_ff @(posedge clk or negedge btn_reset) begin
            if (!btn_reset) begin
                meta       <= 1'b1;
                sync       <= 1'b1;
                db         <= 1'b1;
                db_q       <= 1'b1;
                stable_cnt <= '0;
            end else begin
                meta <= btn_raw[i];
                sync <= meta;
                db_q <= db;
                if (sync == db) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    db         <= sync;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end
        end

        // Only the falling edge of the debounced level is a press; releases are ignored.
        assign press_ev[i] = db_q & ~db;
    end

    assign inc_ev = press_ev[0];
    assign dec_ev = press_ev[1];

    logic [N-1:0] count_nxt;
    logic         overflow_nxt;
    logic         underflow_nxt;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        count_nxt     = count;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        if (load) begin
            count_nxt = load_value;
        end else if (inc_ev && !dec_ev) begin
            if (count == MAX_VAL) begin
                overflow_nxt = 1'b1;
                if (WRAP) count_nxt = '0;
            end else begin
                count_nxt = count + 1'b1;
            end
        end else if (dec_ev && !inc_ev) begin
            if (count == '0) begin
                underflow_nxt = 1'b1;
                if (WRAP) count_nxt = MAX_VAL;
            end else begin
                count_nxt = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            count     <= RESET_VAL;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

endmodule

// File: tb/tb_dcounter_sync.sv
// Drives a saturating and a wrapping dcounter_sync with the same button stimulus;
// expected count events are queued per instance and matched by per-instance monitors.
module tb_dcounter_sync;

    typedef struct packed {
        int         cyc;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       btn_reset = 1'b1;
    logic       btn_increment = 1'b1;
    logic       btn_decrement = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] count_s, count_w;
    logic       at_max_s, at_min_s, ovf_s, unf_s;
    logic       at_max_w, at_min_w, ovf_w, unf_w;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t q_s[$];
    exp_t q_w[$];

    dcounter_sync #(.N(4), .DEBOUNCE_CYCLES(4), .WRAP(1'b0), .RESET_VAL(4'd15)) dut_sat (
        .clk(clk), .btn_reset(btn_reset), .btn_increment(btn_increment),
        .btn_decrement(btn_decrement), .load(load), .load_value(load_value),
        .count(count_s), .at_max(at_max_s), .at_min(at_min_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    dcounter_sync #(.N(4), .DEBOUNCE_CYCLES(4), .WRAP(1'b1), .RESET_VAL(4'd15)) dut_wrap (
        .clk(clk), .btn_reset(btn_reset), .btn_increment(btn_increment),
        .btn_decrement(btn_decrement), .load(load), .load_value(load_value),
        .count(count_w), .at_max(at_max_w), .at_min(at_min_w),
        .overflow(ovf_w), .underflow(unf_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] c, input logic o, input logic u);
        exp_t e;
        e.cyc = 0;
        e.cnt = c;
        e.ovf = o;
        e.unf = u;
        return e;
    endfunction

    // Monitors: any count change or status pulse is an output event and must match the queue head.
    logic [3:0] prev_s, prev_w;
    exp_t       e_s, e_w;

    always @(negedge clk) begin
        if (mon_en && (count_s != prev_s || ovf_s || unf_s)) begin
            if (q_s.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sat_unexpected: count=%0d ovf=%0b unf=%0b at cycle %0d, no event expected",
                         count_s, ovf_s, unf_s, cyc);
            end else begin
                e_s = q_s.pop_front();
                check("sat_event_cycle", cyc, e_s.cyc);
                check("sat_event_state", int'({count_s, ovf_s, unf_s}), int'({e_s.cnt, e_s.ovf, e_s.unf}));
            end
        end
        prev_s = count_s;
    end

    always @(negedge clk) begin
        if (mon_en && (count_w != prev_w || ovf_w || unf_w)) begin
            if (q_w.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wrap_unexpected: count=%0d ovf=%0b unf=%0b at cycle %0d, no event expected",
                         count_w, ovf_w, unf_w, cyc);
            end else begin
                e_w = q_w.pop_front();
                check("wrap_event_cycle", cyc, e_w.cyc);
                check("wrap_event_state", int'({count_w, ovf_w, unf_w}), int'({e_w.cnt, e_w.ovf, e_w.unf}));
            end
        end
        prev_w = count_w;
    end

    // Clean press: buttons low for low_n edges, then high for high_n edges.
    task automatic press(input bit inc, input bit dec, input int low_n, input int high_n,
                         input bit ps, input exp_t es, input bit pw, input exp_t ew);
        int t0;
        @(negedge clk);
        t0 = cyc;
        if (inc) btn_increment = 1'b0;
        if (dec) btn_decrement = 1'b0;
        if (ps) begin es.cyc = t0 + 7; q_s.push_back(es); end
        if (pw) begin ew.cyc = t0 + 7; q_w.push_back(ew); end
        repeat (low_n) @(posedge clk);
        @(negedge clk);
        btn_increment = 1'b1;
        btn_decrement = 1'b1;
        repeat (high_n) @(posedge clk);
    endtask

    task automatic do_load(input logic [3:0] v, input bit ps, input bit pw);
        int t0;
        @(negedge clk);
        t0 = cyc;
        load = 1'b1;
        load_value = v;
        if (ps) begin e_s = mk(v, 1'b0, 1'b0); e_s.cyc = t0 + 1; q_s.push_back(e_s); end
        if (pw) begin e_w = mk(v, 1'b0, 1'b0); e_w.cyc = t0 + 1; q_w.push_back(e_w); end
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int   t0;
        exp_t ex;

        // Reset asserted between edges: outputs take reset values before any edge.
        @(negedge clk);
        #2 btn_reset = 1'b0;
        #1;
        check("reset_count_sat", int'(count_s), 15);
        check("reset_count_wrap", int'(count_w), 15);
        check("reset_at_max", int'(at_max_s), 1);
        check("reset_at_min", int'(at_min_s), 0);
        check("reset_pulses", int'({ovf_s, unf_s, ovf_w, unf_w}), 0);
        repeat (3) @(negedge clk);
        btn_reset = 1'b1;
        #1 mon_en = 1'b1;

        // Three clean decrement presses, each landing at edge 7.
        press(1'b0, 1'b1, 8, 8, 1'b1, mk(4'd14, 1'b0, 1'b0), 1'b1, mk(4'd14, 1'b0, 1'b0));
        press(1'b0, 1'b1, 8, 8, 1'b1, mk(4'd13, 1'b0, 1'b0), 1'b1, mk(4'd13, 1'b0, 1'b0));
        press(1'b0, 1'b1, 8, 8, 1'b1, mk(4'd12, 1'b0, 1'b0), 1'b1, mk(4'd12, 1'b0, 1'b0));

        // Bouncing press: low 2, high 1, then low 13; the debounce restarts, event at edge 10.
        @(negedge clk);
        t0 = cyc;
        btn_decrement = 1'b0;
        ex = mk(4'd11, 1'b0, 1'b0);
        ex.cyc = t0 + 10;
        q_s.push_back(ex);
        q_w.push_back(ex);
        repeat (2) @(posedge clk);
        @(negedge clk) btn_decrement = 1'b1;
        repeat (1) @(posedge clk);
        @(negedge clk) btn_decrement = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk) btn_decrement = 1'b1;
        repeat (10) @(posedge clk);

        // Glitch one clock shorter than the debounce window.
        @(negedge clk) btn_decrement = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) btn_decrement = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("glitch_count_sat", int'(count_s), 11);
        check("glitch_count_wrap", int'(count_w), 11);

        // Top boundary: saturating holds at 15, wrapping rolls to 0, both pulse overflow.
        do_load(4'd15, 1'b1, 1'b1);
        check("load15_at_max", int'(at_max_s), 1);
        press(1'b1, 1'b0, 8, 8, 1'b1, mk(4'd15, 1'b1, 1'b0), 1'b1, mk(4'd0, 1'b1, 1'b0));
        check("sat_at_max_after_inc", int'(at_max_s), 1);
        check("wrap_at_min_after_inc", int'(at_min_w), 1);

        // Bottom boundary: wrapping instance is already 0, so its load shows no change.
        do_load(4'd0, 1'b1, 1'b0);
        check("load0_at_min", int'(at_min_s), 1);
        press(1'b0, 1'b1, 8, 8, 1'b1, mk(4'd0, 1'b0, 1'b1), 1'b1, mk(4'd15, 1'b0, 1'b1));
        check("sat_at_min_after_dec", int'(at_min_s), 1);
        check("wrap_at_max_after_dec", int'(at_max_w), 1);

        // Simultaneous presses cancel.
        do_load(4'd8, 1'b1, 1'b1);
        press(1'b1, 1'b1, 8, 8, 1'b0, mk(4'd0, 1'b0, 1'b0), 1'b0, mk(4'd0, 1'b0, 1'b0));
        check("both_count_sat", int'(count_s), 8);
        check("both_count_wrap", int'(count_w), 8);

        // Load sampled on the same edge as an increment event wins, with no pulse.
        @(negedge clk);
        t0 = cyc;
        btn_increment = 1'b0;
        ex = mk(4'd5, 1'b0, 1'b0);
        ex.cyc = t0 + 7;
        q_s.push_back(ex);
        q_w.push_back(ex);
        repeat (6) @(negedge clk);
        load = 1'b1;
        load_value = 4'd5;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        btn_increment = 1'b1;
        repeat (10) @(posedge clk);

        // Reset two clocks into a debounce; the button stays low through release.
        do_load(4'd7, 1'b1, 1'b1);
        @(negedge clk) btn_decrement = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        #2 btn_reset = 1'b0;
        #1;
        check("midop_reset_sat", int'(count_s), 15);
        check("midop_reset_wrap", int'(count_w), 15);
        repeat (3) @(negedge clk);
        t0 = cyc;
        btn_reset = 1'b1;
        ex = mk(4'd14, 1'b0, 1'b0);
        ex.cyc = t0 + 7;
        q_s.push_back(ex);
        q_w.push_back(ex);
        #1 mon_en = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk) btn_decrement = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);

        check("sat_events_outstanding", q_s.size(), 0);
        check("wrap_events_outstanding", q_w.size(), 0);
        check("final_count_sat", int'(count_s), 14);
        check("final_count_wrap", int'(count_w), 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
